// File: rtl/matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : matrix_pkg                                                   |
// | Description : Shared matrix dimensions, ASCII codes, fault codes and parse |
// |               FSM encoding for the matrix input parser and print stage.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ELEM_W  = 8;

    localparam logic [7:0] c_ascii_space = 8'h20;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;
    localparam logic [7:0] c_ascii_zero  = 8'h30;
    localparam logic [7:0] c_ascii_nine  = 8'h39;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_DIM     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        S_HEIGHT = 2'd0,
        S_WIDTH  = 2'd1,
        S_ELEM   = 2'd2
    } parse_state_t;

endpackage : matrix_pkg
`default_nettype wire

// File: rtl/ascii_digit_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ascii_digit_decode                                           |
// | Description : Classifies a received ASCII byte as separator or decimal     |
// |               digit and returns the digit's binary value.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ascii_digit_decode (
    input  logic [7:0] rx_data,
    output logic       is_sep,
    output logic       is_digit,
    output logic [3:0] value
);
    import matrix_pkg::*;

    logic [7:0] w_diff;

    always_comb begin
        is_sep   = (rx_data == c_ascii_space) ||
                   (rx_data == c_ascii_cr)    ||
                   (rx_data == c_ascii_lf);
        is_digit = (rx_data >= c_ascii_zero) && (rx_data <= c_ascii_nine);
        w_diff   = rx_data - c_ascii_zero;
        value    = is_digit ? w_diff[3:0] : 4'd0;
    end

endmodule : ascii_digit_decode
`default_nettype wire

// File: rtl/matrix_input_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_input_parser                                          |
// | Description : Parses "H W e0 e1 ..." ASCII digit streams into a row-major  |
// |               matrix and commits it atomically with a done pulse.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matrix_input_parser #(
    parameter int MAX_DIM        = matrix_pkg::MAX_DIM,
    parameter int ELEM_W         = matrix_pkg::ELEM_W,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    input  logic                              clear,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] data_output,
    output logic [2:0]                        width,
    output logic [2:0]                        height,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [1:0]                        err_code
);
    import matrix_pkg::*;

    localparam int                c_slots    = MAX_DIM * MAX_DIM;
    localparam int                c_to_w     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_to_w-1:0] c_to_one   = c_to_w'(1);
    localparam logic [3:0]        c_max_dim  = 4'(MAX_DIM);

    logic                      w_is_sep;
    logic                      w_is_digit;
    logic [3:0]                w_value;

    parse_state_t              r_state;
    logic [2:0]                r_h_shadow;
    logic [2:0]                r_w_shadow;
    logic [4:0]                r_total;
    logic [4:0]                r_idx;
    logic [ELEM_W-1:0]         r_shadow [c_slots];
    logic [c_to_w-1:0]         r_to_cnt;

    logic [c_slots*ELEM_W-1:0] r_data;
    logic [2:0]                r_width;
    logic [2:0]                r_height;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;
    err_code_t                 r_err_code;

    logic                      w_byte;
    logic                      w_digit;
    logic                      w_illegal;
    logic                      w_dim_ok;
    logic                      w_dim_fault;
    logic                      w_timeout;
    logic                      w_fault;
    logic                      w_elem_wr;
    logic                      w_commit;
    logic                      w_shadow_clr;
    err_code_t                 w_fault_code;
    logic [c_slots*ELEM_W-1:0] w_commit_data;

    ascii_digit_decode u_decode (
        .rx_data  (rx_data),
        .is_sep   (w_is_sep),
        .is_digit (w_is_digit),
        .value    (w_value)
    );

    // clear wins over the byte: a dropped byte can neither fault nor commit
    always_comb begin
        w_byte       = rx_valid && !clear;
        w_digit      = w_byte && w_is_digit;
        w_illegal    = w_byte && !w_is_digit && !w_is_sep;
        w_dim_ok     = (w_value != 4'd0) && (w_value <= c_max_dim);
        w_dim_fault  = w_digit && (r_state != S_ELEM) && !w_dim_ok;
        w_timeout    = !clear && (r_state != S_HEIGHT) && !w_digit &&
                       (r_to_cnt == c_to_last);
        w_fault      = w_illegal || w_dim_fault || w_timeout;
        w_elem_wr    = w_digit && (r_state == S_ELEM);
        w_commit     = w_elem_wr && (r_idx == (r_total - 5'd1));
        w_shadow_clr = clear || w_fault || w_commit;

        w_fault_code = ERR_NONE;
        if (w_illegal) begin
            w_fault_code = ERR_ILLEGAL;
        end else if (w_dim_fault) begin
            w_fault_code = ERR_DIM;
        end else if (w_timeout) begin
            w_fault_code = ERR_TIMEOUT;
        end
    end

    // Commit image: includes the element arriving this cycle, unused slots zeroed
    for (genvar k = 0; k < c_slots; k++) begin : g_slot
        assign w_commit_data[k*ELEM_W +: ELEM_W] =
            (5'(k) >= r_total)                ? '0              :
            (w_elem_wr && (r_idx == 5'(k)))   ? ELEM_W'(w_value) :
                                                r_shadow[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HEIGHT;
            r_h_shadow <= '0;
            r_w_shadow <= '0;
            r_total    <= '0;
            r_idx      <= '0;
            r_to_cnt   <= '0;
            r_data     <= '0;
            r_width    <= '0;
            r_height   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            for (int k = 0; k < c_slots; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            for (int k = 0; k < c_slots; k++) begin
                if (w_shadow_clr) begin
                    r_shadow[k] <= '0;
                end else if (w_elem_wr && (r_idx == 5'(k))) begin
                    r_shadow[k] <= ELEM_W'(w_value);
                end
            end

            if (clear || w_fault) begin
                r_state  <= S_HEIGHT;
                r_idx    <= '0;
                r_to_cnt <= '0;
                r_busy   <= 1'b0;
                if (w_fault) begin
                    r_error    <= 1'b1;
                    r_err_code <= w_fault_code;
                end
            end else begin
                if ((r_state == S_HEIGHT) || w_digit) begin
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + c_to_one;
                end

                case (r_state)
                    S_HEIGHT: begin
                        if (w_digit) begin
                            r_h_shadow <= w_value[2:0];
                            r_state    <= S_WIDTH;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_WIDTH: begin
                        if (w_digit) begin
                            r_w_shadow <= w_value[2:0];
                            r_total    <= {2'b00, r_h_shadow} * {2'b00, w_value[2:0]};
                            r_idx      <= '0;
                            r_state    <= S_ELEM;
                        end
                    end
                    S_ELEM: begin
                        if (w_commit) begin
                            r_data   <= w_commit_data;
                            r_width  <= r_w_shadow;
                            r_height <= r_h_shadow;
                            r_idx    <= '0;
                            r_state  <= S_HEIGHT;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else if (w_elem_wr) begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                    default: begin
                        r_state <= S_HEIGHT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_output = r_data;
    assign width       = r_width;
    assign height      = r_height;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign err_code    = r_err_code;

endmodule : matrix_input_parser
`default_nettype wire

// File: tb/tb_matrix_input_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matrix_input_parser                                       |
// | Description : Directed self-checking bench for matrix_input_parser.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_matrix_input_parser;

    localparam int c_timeout = 100;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic [7:0]   rx_data  = 8'h00;
    logic         rx_valid = 1'b0;
    logic         clear    = 1'b0;
    logic [199:0] data_output;
    logic [2:0]   width;
    logic [2:0]   height;
    logic         busy;
    logic         done;
    logic         error;
    logic [1:0]   err_code;

    int errors    = 0;
    int checks    = 0;
    int done_cnt  = 0;
    int error_cnt = 0;

    matrix_input_parser #(
        .TIMEOUT_CYCLES (c_timeout)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .clear       (clear),
        .data_output (data_output),
        .width       (width),
        .height      (height),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (error) error_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [199:0] exp_nines;
        int           d_snap;
        int           e_snap;

        exp_nines = '0;
        for (int k = 0; k < 25; k++) begin
            exp_nines[k*8 +: 8] = 8'h09;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_bus("rst_data", data_output, 200'h0);
        chk("rst_width", 32'(width), 0);
        chk("rst_height", 32'(height), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_code", 32'(err_code), 0);
        rst_n = 1'b1;
        idle(2);

        // 2x3 matrix with separators; done exactly one cycle after last digit
        send_str("2 3\r\n1 2 3\r\n4 5 ");
        chk("m23_busy_mid", 32'(busy), 1);
        chk("m23_no_done_early", done_cnt, 0);
        send_byte("6");
        chk("m23_done_pulse", 32'(done), 1);
        chk("m23_height", 32'(height), 2);
        chk("m23_width", 32'(width), 3);
        chk_bus("m23_data", data_output, 200'h060504030201);
        chk("m23_busy_after", 32'(busy), 0);
        send_str("\r\n");
        chk("m23_done_cleared", 32'(done), 0);
        chk("m23_done_count", done_cnt, 1);

        // Height out of range keeps the committed matrix
        send_byte("6");
        chk("dim_error_pulse", 32'(error), 1);
        chk("dim_err_code", 32'(err_code), 2);
        chk("dim_busy", 32'(busy), 0);
        chk_bus("dim_data_held", data_output, 200'h060504030201);
        chk("dim_height_held", 32'(height), 2);
        idle(1);
        chk("dim_error_one_cycle", 32'(error), 0);

        // Full 5x5 of nines, then a byte in the done cycle starts a new parse
        send_str("5 5");
        for (int i = 0; i < 24; i++) begin
            send_byte("9");
        end
        chk("m55_no_done_early", 32'(done), 0);
        send_byte("9");
        chk("m55_done", 32'(done), 1);
        chk_bus("m55_data", data_output, exp_nines);
        chk("m55_width", 32'(width), 5);
        chk("m55_height", 32'(height), 5);
        chk("m55_err_code_kept", 32'(err_code), 2);
        send_byte("3");
        chk("m55_new_height_busy", 32'(busy), 1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("m55_clear_busy", 32'(busy), 0);
        chk("m55_clear_no_error", 32'(error), 0);

        // Illegal character aborts, next matrix parses cleanly
        send_str("2 2 1 x");
        chk("ill_error_pulse", 32'(error), 1);
        chk("ill_err_code", 32'(err_code), 1);
        chk("ill_busy", 32'(busy), 0);
        chk_bus("ill_data_held", data_output, exp_nines);
        send_str("1 1 7");
        chk("m11_done", 32'(done), 1);
        chk("m11_width", 32'(width), 1);
        chk("m11_height", 32'(height), 1);
        chk_bus("m11_data", data_output, 200'h07);

        // Timeout: error appears after exactly TIMEOUT_CYCLES idle edges
        send_str("3 3 1");
        idle(c_timeout - 1);
        chk("to_no_error_early", 32'(error), 0);
        chk("to_busy_before", 32'(busy), 1);
        idle(1);
        chk("to_error_pulse", 32'(error), 1);
        chk("to_err_code", 32'(err_code), 3);
        chk("to_busy_after", 32'(busy), 0);
        chk_bus("to_data_held", data_output, 200'h07);

        // Zero width is a dimension fault
        send_str("1 0");
        chk("w0_error_pulse", 32'(error), 1);
        chk("w0_err_code", 32'(err_code), 2);

        // clear on the final element byte: byte dropped, no pulses
        send_str("1 2 4 ");
        d_snap = done_cnt;
        e_snap = error_cnt;
        rx_data  = "5";
        rx_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        clear    = 1'b0;
        chk("clr_no_done", 32'(done), 0);
        chk("clr_busy", 32'(busy), 0);
        idle(3);
        chk("clr_done_count", done_cnt, d_snap);
        chk("clr_error_count", error_cnt, e_snap);
        chk_bus("clr_data_held", data_output, 200'h07);
        chk("clr_width_held", 32'(width), 1);
        chk("clr_err_code_held", 32'(err_code), 2);

        // Reset mid-matrix zeroes everything, no pulse afterwards
        send_str("2 2 1");
        chk("mrst_busy_before", 32'(busy), 1);
        d_snap = done_cnt;
        e_snap = error_cnt;
        rst_n = 1'b0;
        #1;
        chk_bus("mrst_data", data_output, 200'h0);
        chk("mrst_width", 32'(width), 0);
        chk("mrst_height", 32'(height), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_err_code", 32'(err_code), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(c_timeout + 5);
        chk("mrst_done_count", done_cnt, d_snap);
        chk("mrst_error_count", error_cnt, e_snap);
        chk("mrst_busy_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_matrix_input_parser
`default_nettype wire
